// File: rtl/ir_queue_if.sv
// Fetch/consumer handshake bundle for ir_queue: producer push side, consumer
// head side with raw MIPS field decode, flush and occupancy.
interface ir_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       in_instr_i;
  logic [ADDR_W-1:0] in_pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_instr_o;
  logic [ADDR_W-1:0] out_pc_o;
  logic [5:0]        opcode_o;
  logic [4:0]        rs_o;
  logic [4:0]        rt_o;
  logic [4:0]        rd_o;
  logic [4:0]        shift_o;
  logic [5:0]        funct_o;
  logic [15:0]       immediate_o;
  logic [25:0]       target_o;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_pc_o,
           opcode_o, rs_o, rt_o, rd_o, shift_o, funct_o,
           immediate_o, target_o, count_o
  );

  modport master (
    output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_pc_o,
           opcode_o, rs_o, rt_o, rd_o, shift_o, funct_o,
           immediate_o, target_o, count_o
  );
endinterface

// File: rtl/ir_queue.sv
// DEPTH-entry instruction FIFO between fetch and the control FSM; buffers
// {pc, instr} pairs and decodes the head word's MIPS fields combinationally.
module ir_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int BYPASS = 1
) (
  input  logic    clk,
  input  logic    reset_ni,
  ir_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + ADDR_W;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [31:0]       w_sel_instr;
  logic [ADDR_W-1:0] w_sel_pc;
  logic              w_push;
  logic              w_pop;
  logic              w_write;
  logic              w_read;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_in_ready = !w_full && !bus.flush_i;

  // Head select: stored entry when non-empty, else the incoming word if bypass
  // is enabled. Everything reads as zero (SLL $0 = NOP) when nothing is valid.
  always_comb begin
    w_out_valid = 1'b0;
    w_sel_instr = '0;
    w_sel_pc    = '0;
    if (!bus.flush_i) begin
      if (!w_empty) begin
        w_out_valid = 1'b1;
        {w_sel_pc, w_sel_instr} = r_mem[r_rd_ptr];
      end else if ((BYPASS != 0) && bus.in_valid_i) begin
        w_out_valid = 1'b1;
        w_sel_instr = bus.in_instr_i;
        w_sel_pc    = bus.in_pc_i;
      end
    end
  end

  assign w_push  = bus.in_valid_i && w_in_ready;
  assign w_pop   = w_out_valid && bus.out_ready_i;
  // A bypassed word taken in the same cycle never touches storage.
  assign w_write = w_push && !(w_empty && w_pop);
  assign w_read  = w_pop && !w_empty;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_read)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {bus.in_pc_i, bus.in_instr_i};
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_instr_o = w_sel_instr;
  assign bus.out_pc_o    = w_sel_pc;
  assign bus.opcode_o    = w_sel_instr[31:26];
  assign bus.rs_o        = w_sel_instr[25:21];
  assign bus.rt_o        = w_sel_instr[20:16];
  assign bus.rd_o        = w_sel_instr[15:11];
  assign bus.shift_o     = w_sel_instr[10:6];
  assign bus.funct_o     = w_sel_instr[5:0];
  assign bus.immediate_o = w_sel_instr[15:0];
  assign bus.target_o    = w_sel_instr[25:0];
  assign bus.count_o     = r_count;

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (reset_ni && w_pop)
      $display("ir_queue pop pc=%h instr=%h", w_sel_pc, w_sel_instr);
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset_ni) !(w_push && w_full)
  );
`endif
endmodule

// File: tb/tb_ir_queue.sv
// Randomized bench for ir_queue: BYPASS=0 and BYPASS=1 instances share stimulus
// and are each compared every cycle against a queue-based reference model.
module tb_ir_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  typedef logic [63:0] q_t [$];
  typedef struct {
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    int          cnt;
    logic        push;
    logic        pop;
  } exp_t;

  logic clk = 1'b0;
  logic reset_ni;
  logic drv_flush, drv_valid, drv_ready;
  logic [31:0] drv_instr;
  logic [31:0] drv_pc;

  int n_checks = 0;
  int n_fail   = 0;
  q_t q0, q1;

  always #5 clk = ~clk;

  ir_queue_if #(.DEPTH(DEPTH), .ADDR_W(AW)) if0 ();
  ir_queue_if #(.DEPTH(DEPTH), .ADDR_W(AW)) if1 ();

  assign if0.flush_i     = drv_flush;
  assign if0.in_valid_i  = drv_valid;
  assign if0.in_instr_i  = drv_instr;
  assign if0.in_pc_i     = drv_pc;
  assign if0.out_ready_i = drv_ready;
  assign if1.flush_i     = drv_flush;
  assign if1.in_valid_i  = drv_valid;
  assign if1.in_instr_i  = drv_instr;
  assign if1.in_pc_i     = drv_pc;
  assign if1.out_ready_i = drv_ready;

  ir_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .BYPASS(0)) u_dut0 (
    .clk(clk), .reset_ni(reset_ni), .bus(if0.slave)
  );
  ir_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .BYPASS(1)) u_dut1 (
    .clk(clk), .reset_ni(reset_ni), .bus(if1.slave)
  );

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t eval(bit byp, q_t q);
    exp_t e;
    e.ready = (q.size() != DEPTH) && !drv_flush;
    e.valid = 1'b0;
    e.instr = '0;
    e.pc    = '0;
    if (!drv_flush) begin
      if (q.size() > 0) begin
        e.valid = 1'b1;
        e.instr = q[0][31:0];
        e.pc    = q[0][63:32];
      end else if (byp && drv_valid) begin
        e.valid = 1'b1;
        e.instr = drv_instr;
        e.pc    = drv_pc;
      end
    end
    e.cnt  = q.size();
    e.push = drv_valid && e.ready;
    e.pop  = e.valid && drv_ready;
    return e;
  endfunction

  function automatic q_t nxt(q_t q, exp_t e);
    if (drv_flush) q.delete();
    else if (!(q.size() == 0 && e.pop)) begin
      if (e.pop)  void'(q.pop_front());
      if (e.push) q.push_back({drv_pc, drv_instr});
    end
    return q;
  endfunction

  task automatic check_dut(int n, exp_t e);
    logic ov, ir;
    logic [31:0] oi, op;
    logic [2:0] cn;
    logic [5:0] opc, fn;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] im;
    logic [25:0] tg;
    string p;
    if (n == 0) begin
      ov = if0.out_valid_o; ir = if0.in_ready_o; oi = if0.out_instr_o; op = if0.out_pc_o;
      cn = if0.count_o; opc = if0.opcode_o; fn = if0.funct_o; rs = if0.rs_o; rt = if0.rt_o;
      rd = if0.rd_o; sh = if0.shift_o; im = if0.immediate_o; tg = if0.target_o;
    end else begin
      ov = if1.out_valid_o; ir = if1.in_ready_o; oi = if1.out_instr_o; op = if1.out_pc_o;
      cn = if1.count_o; opc = if1.opcode_o; fn = if1.funct_o; rs = if1.rs_o; rt = if1.rt_o;
      rd = if1.rd_o; sh = if1.shift_o; im = if1.immediate_o; tg = if1.target_o;
    end
    p = $sformatf("byp%0d@%0t", n, $time);
    chk({p, " out_valid"}, 64'(ov), 64'(e.valid));
    chk({p, " in_ready"},  64'(ir), 64'(e.ready));
    chk({p, " count"},     64'(cn), 64'(e.cnt));
    chk({p, " instr"},     64'(oi), 64'(e.instr));
    chk({p, " pc"},        64'(op), 64'(e.pc));
    chk({p, " opcode"},    64'(opc), 64'(e.instr / 32'h0400_0000));
    chk({p, " rs"},        64'(rs), 64'((e.instr >> 21) % 32));
    chk({p, " rt"},        64'(rt), 64'((e.instr >> 16) % 32));
    chk({p, " rd"},        64'(rd), 64'((e.instr >> 11) % 32));
    chk({p, " shift"},     64'(sh), 64'((e.instr >> 6) % 32));
    chk({p, " funct"},     64'(fn), 64'(e.instr % 64));
    chk({p, " imm"},       64'(im), 64'(e.instr % 65536));
    chk({p, " target"},    64'(tg), 64'(e.instr % 32'h0400_0000));
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    exp_t e0, e1;
    e0 = eval(1'b0, q0);
    e1 = eval(1'b1, q1);
    @(negedge clk);
    check_dut(0, e0);
    check_dut(1, e1);
    @(posedge clk);
    q0 = nxt(q0, e0);
    q1 = nxt(q1, e1);
    #1;
  endtask

  task automatic set_in(logic v, logic r, logic [31:0] w);
    drv_valid = v;
    drv_ready = r;
    drv_instr = w;
    drv_pc    = 32'hBFC0_0000 + 32'($urandom_range(0, 255)) * 4;
  endtask

  initial begin
    drv_flush = 1'b0;
    set_in(1'b0, 1'b0, 32'h0);
    reset_ni = 1'b0;
    #3;
    chk("rst_valid0", 64'(if0.out_valid_o), 64'd0);
    chk("rst_ready0", 64'(if0.in_ready_o), 64'd1);
    chk("rst_count0", 64'(if0.count_o), 64'd0);
    chk("rst_instr0", 64'(if0.out_instr_o), 64'd0);
    chk("rst_valid1", 64'(if1.out_valid_o), 64'd0);
    chk("rst_count1", 64'(if1.count_o), 64'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;

    // first push, one-cycle latency without bypass
    set_in(1'b1, 1'b0, 32'h2402_0005);
    drv_pc = 32'hBFC0_0000;
    step();
    set_in(1'b0, 1'b0, 32'h0);
    chk("p1_valid",  64'(if0.out_valid_o), 64'd1);
    chk("p1_opcode", 64'(if0.opcode_o), 64'h09);
    chk("p1_rt",     64'(if0.rt_o), 64'd2);
    chk("p1_imm",    64'(if0.immediate_o), 64'h0005);
    chk("p1_pc",     64'(if0.out_pc_o), 64'hBFC0_0000);
    chk("p1_count",  64'(if0.count_o), 64'd1);
    step();

    // fill to full, fifth word refused, then drain in order
    for (int i = 0; i < 3; i++) begin set_in(1'b1, 1'b0, $urandom); step(); end
    set_in(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("full_count", 64'(if0.count_o), 64'd4);
    chk("full_ready", 64'(if0.in_ready_o), 64'd0);
    step();
    chk("full_hold",  64'(if0.count_o), 64'd4);
    for (int i = 0; i < 4; i++) begin set_in(1'b0, 1'b1, 32'h0); step(); end
    chk("drain_count", 64'(if0.count_o), 64'd0);

    // steady stream across pointer wrap
    for (int i = 0; i < 2; i++) begin set_in(1'b1, 1'b0, $urandom); step(); end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b1, $urandom);
      step();
      chk("stream_count", 64'(if0.count_o), 64'd2);
    end
    for (int i = 0; i < 3; i++) begin set_in(1'b0, 1'b1, 32'h0); step(); end

    // same-cycle bypass into an empty queue
    set_in(1'b1, 1'b1, 32'h0085_1021);
    #1;
    chk("byp_valid", 64'(if1.out_valid_o), 64'd1);
    chk("byp_funct", 64'(if1.funct_o), 64'h21);
    chk("byp_rd",    64'(if1.rd_o), 64'd2);
    chk("nobyp_valid", 64'(if0.out_valid_o), 64'd0);
    step();
    chk("byp_count", 64'(if1.count_o), 64'd0);
    set_in(1'b0, 1'b1, 32'h0);
    step();

    // flush with 3 stored and a same-cycle push
    for (int i = 0; i < 3; i++) begin set_in(1'b1, 1'b0, $urandom); step(); end
    set_in(1'b1, 1'b1, $urandom);
    drv_flush = 1'b1;
    #1;
    chk("fl_valid", 64'(if0.out_valid_o), 64'd0);
    chk("fl_ready", 64'(if0.in_ready_o), 64'd0);
    step();
    drv_flush = 1'b0;
    set_in(1'b0, 1'b0, 32'h0);
    #1;
    chk("fl_count", 64'(if0.count_o), 64'd0);
    chk("fl_after_valid", 64'(if0.out_valid_o), 64'd0);
    step();

    // asynchronous reset between edges with 2 stored
    for (int i = 0; i < 2; i++) begin set_in(1'b1, 1'b0, $urandom); step(); end
    set_in(1'b0, 1'b0, 32'h0);
    #1 reset_ni = 1'b0;
    #1;
    chk("ar_valid0", 64'(if0.out_valid_o), 64'd0);
    chk("ar_count0", 64'(if0.count_o), 64'd0);
    chk("ar_count1", 64'(if1.count_o), 64'd0);
    q0.delete();
    q1.delete();
    #1 reset_ni = 1'b1;
    set_in(1'b1, 1'b0, 32'h8C43_0010);
    step();
    set_in(1'b0, 1'b0, 32'h0);
    chk("ar_head", 64'(if0.out_instr_o), 64'h8C43_0010);
    step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom);
      drv_flush = ($urandom_range(0, 19) == 0);
      step();
    end
    drv_flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
